// File: rtl/core_multicycle.sv
// core_multicycle: multi-cycle RV32I/RV32E core with one shared memory port
module core_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        CLOCK,
    input  logic        RST_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] PC,
    output logic        retire,
    output logic        trap
);
    localparam int   AW    = (NREGS == 16) ? 4 : 5;
    localparam logic RV32E = (NREGS == 16);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t      st;
    logic [31:0] ir, a, b, imm, res;
    logic [31:0] rf [NREGS];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2, sh;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_lw, is_sw, is_opi, is_op;
    logic        legal, bad_reg, cond, taken, fault;
    logic [31:0] r1, r2, imm_d, op2, sra, alu, addr, pimm, tgt, ex_res;

    assign opc = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_br    = opc == 7'b1100011;
    assign is_lw    = opc == 7'b0000011;
    assign is_sw    = opc == 7'b0100011;
    assign is_opi   = opc == 7'b0010011;
    assign is_op    = opc == 7'b0110011;

    assign legal = is_lui | is_auipc | is_jal | (is_jalr & f3 == 3'b000)
                 | (is_br & f3[2:1] != 2'b01)
                 | ((is_lw | is_sw) & f3 == 3'b010)
                 | (is_opi & (f3 == 3'b001 ? f7 == 7'h00 :
                              f3 == 3'b101 ? (f7 == 7'h00 | f7 == 7'h20) : 1'b1))
                 | (is_op & (f7 == 7'h00 | (f7 == 7'h20 & (f3 == 3'b000 | f3 == 3'b101))));

    // Only fields that the format actually uses as register indices can fault on RV32E.
    assign bad_reg = RV32E & ((~(is_br | is_sw) & rd[4])
                            | (~(is_lui | is_auipc | is_jal) & rs1[4])
                            | ((is_op | is_br | is_sw) & rs2[4]));

    assign r1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1[AW-1:0]];
    assign r2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2[AW-1:0]];

    assign imm_d = is_sw ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                   is_br ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                   (is_lui | is_auipc) ? {ir[31:12], 12'b0} :
                   is_jal ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                   {{20{ir[31]}}, ir[31:20]};

    assign op2  = is_op ? b : imm;
    assign sh   = op2[4:0];
    assign sra  = $signed(a) >>> sh;
    assign addr = a + imm;
    assign pimm = PC + imm;
    assign tgt  = is_jalr ? {addr[31:1], 1'b0} : pimm;

    assign cond  = f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b;
    assign taken = cond ^ f3[0];

    assign fault = ~legal | bad_reg
                 | ((is_lw | is_sw) & addr[1:0] != 2'b00)
                 | ((is_jal | is_jalr | (is_br & taken)) & tgt[1:0] != 2'b00);

    // ALU result for OP and OP-IMM, selected by funct3
    always_comb begin
        alu = a + op2;
        case (f3)
            3'b000:  alu = (is_op & f7[5]) ? a - op2 : a + op2;
            3'b001:  alu = a << sh;
            3'b010:  alu = {31'b0, $signed(a) < $signed(op2)};
            3'b011:  alu = {31'b0, a < op2};
            3'b100:  alu = a ^ op2;
            3'b101:  alu = f7[5] ? sra : a >> sh;
            3'b110:  alu = a | op2;
            default: alu = a & op2;
        endcase
    end

    assign ex_res = is_lui ? imm : is_auipc ? pimm : (is_jal | is_jalr) ? PC + 32'd4 :
                    (is_lw | is_sw) ? addr : alu;

    assign mem_req   = RST_n & (st == FETCH | st == MEM);
    assign mem_we    = st == MEM & is_sw;
    assign mem_addr  = (st == MEM) ? res : PC;
    assign mem_wdata = b;
    assign retire    = RST_n & ((st == WB) | (st == EXEC & is_br & ~fault)
                              | (st == MEM & is_sw & mem_ack));

    // Instruction sequencer, architectural state and register file
    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            st   <= FETCH;
            PC   <= RESET_PC;
            trap <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            case (st)
                FETCH: if (mem_ack) begin
                    ir <= mem_rdata;
                    st <= DECODE;
                end
                DECODE: begin
                    a   <= r1;
                    b   <= r2;
                    imm <= imm_d;
                    st  <= EXEC;
                end
                EXEC: if (fault) begin
                    trap <= 1'b1;
                    st   <= TRAP;
                end else if (is_br) begin
                    PC <= taken ? pimm : PC + 32'd4;
                    st <= FETCH;
                end else begin
                    res <= ex_res;
                    if (is_jal | is_jalr) PC <= tgt;
                    st <= (is_lw | is_sw) ? MEM : WB;
                end
                MEM: if (mem_ack) begin
                    if (is_sw) begin
                        PC <= PC + 32'd4;
                        st <= FETCH;
                    end else begin
                        res <= mem_rdata;
                        st  <= WB;
                    end
                end
                WB: begin
                    if (rd != 5'd0) rf[rd[AW-1:0]] <= res;
                    if (!(is_jal | is_jalr)) PC <= PC + 32'd4;
                    st <= FETCH;
                end
                default: st <= TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_core_multicycle.sv
// tb_core_multicycle: directed programs with retire/store scoreboard for core_multicycle
module tb_core_multicycle;
    localparam logic [6:0] OPI = 7'h13, LD = 7'h03, JALR = 7'h67;

    logic        clk = 1'b0;
    logic        rst = 1'b0, sel = 1'b0, clr = 1'b0, ack_force = 1'b0;
    logic        rst_a, rst_b, ack, ack_a, ack_b;
    logic        req_a, we_a, ret_a, trap_a, req_b, we_b, ret_b, trap_b;
    logic [31:0] addr_a, wdata_a, pc_a, addr_b, wdata_b, pc_b, rdata;
    logic        req_m, we_m, ret_m, trap_m;
    logic [31:0] addr_m, wdata_m, pc_m;
    logic [7:0]  idx;
    logic [31:0] pgm [256];
    logic [31:0] dmem [256];
    logic [255:0] dval;
    logic [63:0] e;
    int          vec = 0, errs = 0, cyc = 0, dly = 0, wcnt = 0;
    int          ret_q[$];
    logic [63:0] st_q[$];
    int          rl [15] = '{1, 2, 3, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 0};
    logic [31:0] ev [15] = '{32'd5, 32'hFFFF_FFFE, 32'd7, 32'h28, 32'hFFFF_FFFF, 32'hF, 32'd1,
                             32'd0, 32'hFFFF_FFFA, 32'h1234_5000, 32'h1028, 32'h00FF_FFFF,
                             32'h2F, 32'hFFFF_FFFA, 32'd0};

    always #5 clk = ~clk;

    assign rst_a   = sel ? 1'b0 : rst;
    assign rst_b   = sel ? rst : 1'b0;
    assign req_m   = sel ? req_b : req_a;
    assign we_m    = sel ? we_b : we_a;
    assign addr_m  = sel ? addr_b : addr_a;
    assign wdata_m = sel ? wdata_b : wdata_a;
    assign pc_m    = sel ? pc_b : pc_a;
    assign ret_m   = sel ? ret_b : ret_a;
    assign trap_m  = sel ? trap_b : trap_a;
    assign ack     = (req_m && wcnt >= dly) || ack_force;
    assign ack_a   = ~sel & ack;
    assign ack_b   = sel & ack;
    assign idx     = addr_m[9:2];
    assign rdata   = dval[idx] ? dmem[idx] : pgm[idx];

    core_multicycle #(.RESET_PC(32'h0), .NREGS(32)) u_a (
        .CLOCK(clk), .RST_n(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata), .mem_ack(ack_a), .PC(pc_a),
        .retire(ret_a), .trap(trap_a));

    core_multicycle #(.RESET_PC(32'h0), .NREGS(16)) u_b (
        .CLOCK(clk), .RST_n(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(rdata), .mem_ack(ack_b), .PC(pc_b),
        .retire(ret_b), .trap(trap_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] im, input logic [31:0] r1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {im[11:0], r1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] r2,
                                          input logic [31:0] r1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] im, input logic [31:0] r2,
                                          input logic [31:0] r1);
        return {im[11:5], r2[4:0], r1[4:0], 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] im, input logic [31:0] r2,
                                          input logic [31:0] r1, input logic [31:0] f3);
        return {im[12], im[10:5], r2[4:0], r1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] im, input logic [31:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic put(input int ad, input logic [31:0] w);
        pgm[ad >> 2] = w;
    endtask

    task automatic clear_pgm();
        for (int i = 0; i < 256; i++) pgm[i] = 32'd0;
    endtask

    task automatic exp_st(input logic [31:0] ad, input logic [31:0] d);
        st_q.push_back({ad, d});
    endtask

    task automatic do_reset(input logic s);
        @(posedge clk) #1;
        rst = 1'b0;
        sel = s;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        chk("rst_req", 32'(req_m), 32'd0);
        chk("rst_trap", 32'(trap_m), 32'd0);
        chk("rst_retire", 32'(ret_m), 32'd0);
        chk("rst_pc", pc_m, 32'd0);
        rst = 1'b1;
    endtask

    task automatic run_to_trap(input logic [31:0] pc_exp, input int budget);
        int n = 0;
        logic busy = 1'b0;
        while (!trap_m && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("trap_set", 32'(trap_m), 32'd1);
        chk("trap_pc", pc_m, pc_exp);
        repeat (6) begin
            @(negedge clk);
            busy = busy | req_m | ret_m | ~trap_m;
        end
        chk("trap_quiet", 32'(busy), 32'd0);
        chk("retires_left", 32'(ret_q.size()), 32'd0);
        chk("stores_left", 32'(st_q.size()), 32'd0);
    endtask

    // memory model: ack after dly wait cycles, stores shadow the program image
    always @(posedge clk) begin
        wcnt <= (!rst || !req_m || ack) ? 0 : wcnt + 1;
        if (clr) dval <= '0;
        else if (req_m && ack && we_m) begin
            dmem[idx] <= wdata_m;
            dval[idx] <= 1'b1;
        end
    end

    // scoreboard: retire cycles and store transfers popped as the DUT produces them
    always @(negedge clk) begin
        if (!rst) cyc = 0;
        else begin
            cyc++;
            if (ret_m) begin
                if (ret_q.size() == 0) chk("retire_extra", 32'(cyc), 32'd0);
                else chk("retire_cycle", 32'(cyc), 32'(ret_q.pop_front()));
            end
            if (req_m && ack && we_m) begin
                if (st_q.size() == 0) chk("store_extra", addr_m, 32'hFFFF_FFFF);
                else begin
                    e = st_q.pop_front();
                    chk("store_addr", addr_m, e[63:32]);
                    chk("store_data", wdata_m, e[31:0]);
                end
            end
        end
    end

    initial begin
        // ALU program, zero-wait: every instruction retires 4 cycles after the previous
        clear_pgm();
        dly = 0;
        put(0,  enc_i(5, 0, 0, 1, OPI));
        put(4,  enc_i(-7, 1, 0, 2, OPI));
        put(8,  enc_r(7'h20, 2, 1, 0, 3));
        put(12, enc_i(3, 1, 1, 8, OPI));
        put(16, enc_i(32'h401, 2, 5, 9, OPI));
        put(20, enc_i(28, 2, 5, 10, OPI));
        put(24, enc_r(0, 2, 1, 3, 11));
        put(28, enc_r(0, 2, 1, 2, 12));
        put(32, enc_i(-1, 1, 4, 13, OPI));
        put(36, {20'h12345, 5'd14, 7'h37});
        put(40, {20'h00001, 5'd15, 7'h17});
        put(44, enc_r(0, 8, 2, 5, 16));
        put(48, enc_r(0, 8, 3, 6, 17));
        put(52, enc_r(0, 13, 2, 7, 18));
        put(56, enc_i(1, 1, 0, 0, OPI));
        for (int k = 0; k < 15; k++) begin
            put(60 + 4 * k, enc_s(32'h100 + 32'(4 * k), 32'(rl[k]), 0));
            exp_st(32'h100 + 32'(4 * k), ev[k]);
        end
        for (int k = 1; k <= 30; k++) ret_q.push_back(4 * k);
        do_reset(1'b0);
        run_to_trap(32'd120, 300);

        // store then load through address 8 with one wait state per access
        clear_pgm();
        dly = 1;
        put(0,     enc_j(32'h40, 0));
        put(32'h40, enc_i(5, 0, 0, 1, OPI));
        put(32'h44, enc_s(8, 1, 0));
        put(32'h48, enc_i(8, 0, 2, 4, LD));
        put(32'h4C, enc_s(32'h100, 4, 0));
        exp_st(32'h8, 32'd5);
        exp_st(32'h100, 32'd5);
        ret_q = '{5, 10, 16, 23, 29};
        do_reset(1'b0);
        run_to_trap(32'h50, 200);

        // BLT taken skips an illegal word, BLTU with the same operands falls through
        clear_pgm();
        dly = 0;
        put(0,  enc_i(5, 0, 0, 1, OPI));
        put(4,  enc_i(-2, 0, 0, 2, OPI));
        put(8,  enc_b(8, 1, 2, 4));
        put(16, enc_b(8, 1, 2, 6));
        put(20, enc_s(32'h100, 2, 0));
        exp_st(32'h100, 32'hFFFF_FFFE);
        ret_q = '{4, 8, 11, 14, 18};
        do_reset(1'b0);
        run_to_trap(32'd24, 200);

        // aligned JALR links and jumps; misaligned JALR target traps without writing rd
        clear_pgm();
        put(0,  enc_i(32'h100, 0, 0, 1, OPI));
        put(4,  enc_i(-240, 1, 0, 6, JALR));
        put(16, enc_s(32'h200, 6, 0));
        put(20, enc_i(3, 1, 0, 5, JALR));
        exp_st(32'h200, 32'd8);
        ret_q = '{4, 8, 12};
        do_reset(1'b0);
        run_to_trap(32'd20, 200);
        chk("jalr_rd_unwritten", u_a.rf[5], 32'd0);

        // RV32E instance: register index 20 is illegal
        clear_pgm();
        put(0,  enc_i(1, 0, 0, 1, OPI));
        put(4,  enc_i(2, 0, 0, 2, OPI));
        put(8,  enc_s(32'h100, 2, 0));
        put(12, enc_r(0, 2, 1, 0, 20));
        exp_st(32'h100, 32'd2);
        ret_q = '{4, 8, 12};
        do_reset(1'b1);
        run_to_trap(32'd12, 200);
        chk("rv32e_x4_unchanged", u_b.rf[4], 32'd0);
        chk("rv32e_x1_kept", u_b.rf[1], 32'd1);

        // reset during a stalled LW, with a stray ack while reset is held
        clear_pgm();
        dly = 0;
        put(0, enc_i(32'h100, 0, 2, 7, LD));
        put(4, enc_s(32'h104, 7, 0));
        pgm[64] = 32'h0000_1234;
        do_reset(1'b0);
        @(posedge clk) #1 dly = 20;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_req", 32'(req_m), 32'd1);
        chk("stall_addr", addr_m, 32'h100);
        rst = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 32'(req_m), 32'd0);
        repeat (2) @(posedge clk);
        #1 ack_force = 1'b0;
        dly = 0;
        chk("rst_mid_pc", pc_m, 32'd0);
        chk("rst_mid_rd", u_a.rf[7], 32'd0);
        ret_q = '{5, 9};
        exp_st(32'h104, 32'h1234);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(req_m), 32'd1);
        chk("restart_addr", addr_m, 32'd0);
        run_to_trap(32'd8, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
